// File: rtl/seq_pkg.sv
// Shared phase encoding and elaboration-time helpers for the stage sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_START = 3'd1,
        PH_WAIT  = 3'd2,
        PH_PAUSE = 3'd3,
        PH_SHOW  = 3'd4,
        PH_ERROR = 3'd7
    } phase_t;

    // Index width with a floor of one bit so a single-stage build still has a port.
    function automatic int index_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

    // Highest paused stage strictly below idx, or -1 when there is none.
    function automatic int prev_pause(input logic [31:0] mask, input int idx);
        int p;
        p = -1;
        for (int i = 0; i < idx; i++) begin
            if (mask[i]) p = i;
        end
        return p;
    endfunction

    function automatic int last_pause(input logic [31:0] mask, input int n);
        return prev_pause(mask, n);
    endfunction

endpackage

// File: rtl/dir_button_edge.sv
// Splits the enter button into forward/backward presses by the switch and
// reports one-cycle rising edges of each.
module dir_button_edge (
    input  logic clk,
    input  logic reset,
    input  logic button,
    input  logic switch,
    output logic fwd_edge,
    output logic back_edge
);

    logic fwd;
    logic back;
    logic fwd_q;
    logic back_q;

    assign fwd  = switch & button;
    assign back = ~switch & button;

    // History resets to "held" so a button pressed through reset is not a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_q  <= 1'b1;
            back_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, as real hardware does.
            fwd_q  <= fwd;
            back_q <= back;
        end
    end

    assign fwd_edge  = fwd & ~fwd_q;
    assign back_edge = back & ~back_q;

endmodule

// File: rtl/stage_sequencer.sv
// Top-level control FSM: steps a frame through the processing stages with
// start/done handshakes, review pauses and an optional per-stage watchdog.
module stage_sequencer
    import seq_pkg::*;
#(
    parameter int                    NUM_STAGES     = 3,
    parameter logic [NUM_STAGES-1:0] PAUSE_MASK     = NUM_STAGES'(3'b001),
    parameter int                    TIMEOUT_CYCLES = 0,
    parameter int                    TW             = 32,
    localparam int                   IW             = index_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button_enter,
    input  logic                  switch,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [IW-1:0]         stage_index,
    output logic [2:0]            phase,
    output logic                  pause_entry,
    output logic                  timeout_err
);

    localparam int            LAST_PAUSE = last_pause(32'(PAUSE_MASK), NUM_STAGES);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_STAGES - 1);

    phase_t          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [TW-1:0]   wd, wd_d;
    logic            pe_q, pe_d;
    logic            fwd_edge, back_edge;
    logic            wd_hit;
    logic            is_last;

    dir_button_edge u_edge (
        .clk       (clk),
        .reset     (reset),
        .button    (button_enter),
        .switch    (switch),
        .fwd_edge  (fwd_edge),
        .back_edge (back_edge)
    );

    // Backward-step targets are fixed by the mask, so build them as constant tables.
    logic [NUM_STAGES-1:0] prev_valid;
    logic [IW-1:0]         prev_idx [NUM_STAGES];

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_prev
        localparam int P = prev_pause(32'(PAUSE_MASK), g);
        assign prev_valid[g] = (P >= 0);
        assign prev_idx[g]   = IW'((P >= 0) ? P : 0);
    end

    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (wd == TW'(TIMEOUT_CYCLES - 1));
    assign is_last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PH_IDLE;
            idx   <= '0;
            wd    <= '0;
            pe_q  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            wd    <= wd_d;
            pe_q  <= pe_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state;
        idx_d   = idx;
        wd_d    = wd;
        pe_d    = 1'b0;
        unique case (state)
            PH_IDLE: begin
                if (fwd_edge) begin
                    state_d = PH_START;
                    idx_d   = '0;
                end
            end
            PH_START: begin
                state_d = PH_WAIT;
                wd_d    = '0;
            end
            PH_WAIT: begin
                wd_d = wd + 1'b1;
                if (stage_done[idx]) begin
                    if (PAUSE_MASK[idx]) begin
                        state_d = PH_PAUSE;
                        pe_d    = 1'b1;
                    end else if (is_last) begin
                        state_d = PH_SHOW;
                    end else begin
                        state_d = PH_START;
                        idx_d   = idx + 1'b1;
                    end
                end else if (wd_hit) begin
                    state_d = PH_ERROR;
                end
            end
            PH_PAUSE: begin
                if (fwd_edge) begin
                    if (is_last) begin
                        state_d = PH_SHOW;
                    end else begin
                        state_d = PH_START;
                        idx_d   = idx + 1'b1;
                    end
                end else if (back_edge) begin
                    if (prev_valid[idx]) begin
                        idx_d = prev_idx[idx];
                    end else begin
                        state_d = PH_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            PH_SHOW: begin
                if (back_edge) begin
                    if (LAST_PAUSE >= 0) begin
                        state_d = PH_PAUSE;
                        idx_d   = IW'(LAST_PAUSE);
                    end else begin
                        state_d = PH_IDLE;
                        idx_d   = '0;
                    end
                end
            end
            PH_ERROR: begin
                if (back_edge) begin
                    state_d = PH_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = PH_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    assign stage_start = (state == PH_START) ? (NUM_STAGES'(1) << idx) : '0;
    assign stage_index = idx;
    assign phase       = state;
    assign pause_entry = pe_q;
    assign timeout_err = (state == PH_ERROR);

endmodule
